// File: rtl/wr_tag_pipeline_pkg.sv
// Shared types for the destination-tag pipeline and the forwarding interface it drives.
package wr_tag_pipeline_pkg;

    typedef struct packed {
        logic [4:0] addr;
        logic       en;
        logic       is_load;
    } StageTag;

    localparam StageTag TAG_BUBBLE = '0;

    typedef struct packed {
        logic [4:0] ID;
        logic [4:0] EX;
        logic [4:0] MEM;
        logic [4:0] WB;
    } PipeLineSignal_5;

    typedef struct packed {
        logic ID;
        logic EX;
        logic MEM;
        logic WB;
    } PipeLineSignal_1;

endpackage

// File: rtl/stage_tag_reg.sv
// One pipeline stage's destination tag; i_bubble loads an empty tag instead of i_tag.
module stage_tag_reg
    import wr_tag_pipeline_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_bubble,
    input  StageTag i_tag,
    output StageTag o_tag
);

    StageTag r_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag <= TAG_BUBBLE;
        end else if (i_bubble) begin
            r_tag <= TAG_BUBBLE;
        end else begin
            r_tag <= i_tag;
        end
    end

    assign o_tag = r_tag;

endmodule

// File: rtl/wr_tag_pipeline.sv
// Carries rd tags through EX/MEM/WB for forwarding and stalls one cycle on a load-use hazard.
module wr_tag_pipeline
    import wr_tag_pipeline_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             id_wr_addr,
    input  logic                   id_wr_en,
    input  logic                   id_is_load,
    input  logic [4:0]             id_rd_addr_1,
    input  logic [4:0]             id_rd_addr_2,
    input  logic                   id_rd_use_1,
    input  logic                   id_rd_use_2,
    input  logic                   flush,
    output PipeLineSignal_5        reg_file_wr_addr,
    output PipeLineSignal_1        reg_file_wr_en_cntrl,
    output PipeLineSignal_5        reg_file_rd_addr_1,
    output PipeLineSignal_5        reg_file_rd_addr_2,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] CntOne = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic                   w_id_en;
    StageTag                w_id_tag;
    StageTag                w_ex_tag;
    StageTag                w_mem_tag;
    StageTag                w_wb_tag;
    logic                   w_stall;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Writes to x0 are dropped here so they can never look like a hazard downstream.
    assign w_id_en  = id_wr_en & (id_wr_addr != 5'd0);
    assign w_id_tag = '{addr: id_wr_addr, en: w_id_en, is_load: id_is_load};

    stage_tag_reg u_ex_reg (
        .clk      (clk),
        .rst      (rst),
        .i_bubble (w_stall | flush),
        .i_tag    (w_id_tag),
        .o_tag    (w_ex_tag)
    );

    stage_tag_reg u_mem_reg (
        .clk      (clk),
        .rst      (rst),
        .i_bubble (1'b0),
        .i_tag    (w_ex_tag),
        .o_tag    (w_mem_tag)
    );

    stage_tag_reg u_wb_reg (
        .clk      (clk),
        .rst      (rst),
        .i_bubble (1'b0),
        .i_tag    (w_mem_tag),
        .o_tag    (w_wb_tag)
    );

    // A load's data only exists after MEM, so a reader directly behind it must wait a cycle.
    assign w_stall = w_ex_tag.is_load & w_ex_tag.en &
                     ((id_rd_use_1 & (id_rd_addr_1 == w_ex_tag.addr)) |
                      (id_rd_use_2 & (id_rd_addr_2 == w_ex_tag.addr)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CntOne;
        end
    end

    always_comb begin
        reg_file_wr_addr         = '0;
        reg_file_wr_addr.ID      = id_wr_addr;
        reg_file_wr_addr.EX      = w_ex_tag.addr;
        reg_file_wr_addr.MEM     = w_mem_tag.addr;
        reg_file_wr_addr.WB      = w_wb_tag.addr;
        reg_file_wr_en_cntrl     = '0;
        reg_file_wr_en_cntrl.ID  = w_id_en;
        reg_file_wr_en_cntrl.EX  = w_ex_tag.en;
        reg_file_wr_en_cntrl.MEM = w_mem_tag.en;
        reg_file_wr_en_cntrl.WB  = w_wb_tag.en;
        reg_file_rd_addr_1       = '0;
        reg_file_rd_addr_1.ID    = id_rd_addr_1;
        reg_file_rd_addr_2       = '0;
        reg_file_rd_addr_2.ID    = id_rd_addr_2;
    end

    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_wr_tag_pipeline.sv
// Directed bench for wr_tag_pipeline; narrow stall counter so saturation is reachable quickly.
module tb_wr_tag_pipeline;
    import wr_tag_pipeline_pkg::*;

    localparam int unsigned CntW   = 4;
    localparam int unsigned CntMax = (1 << CntW) - 1;

    logic            clk;
    logic            rst;
    logic [4:0]      id_wr_addr;
    logic            id_wr_en;
    logic            id_is_load;
    logic [4:0]      id_rd_addr_1;
    logic [4:0]      id_rd_addr_2;
    logic            id_rd_use_1;
    logic            id_rd_use_2;
    logic            flush;
    PipeLineSignal_5 wr_addr;
    PipeLineSignal_1 wr_en;
    PipeLineSignal_5 rd_addr_1;
    PipeLineSignal_5 rd_addr_2;
    logic            stall;
    logic [CntW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    wr_tag_pipeline #(
        .STALL_CNT_W (CntW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .id_wr_addr           (id_wr_addr),
        .id_wr_en             (id_wr_en),
        .id_is_load           (id_is_load),
        .id_rd_addr_1         (id_rd_addr_1),
        .id_rd_addr_2         (id_rd_addr_2),
        .id_rd_use_1          (id_rd_use_1),
        .id_rd_use_2          (id_rd_use_2),
        .flush                (flush),
        .reg_file_wr_addr     (wr_addr),
        .reg_file_wr_en_cntrl (wr_en),
        .reg_file_rd_addr_1   (rd_addr_1),
        .reg_file_rd_addr_2   (rd_addr_2),
        .stall                (stall),
        .stall_cnt            (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rd, input logic en, input logic ld);
        id_wr_addr = rd;
        id_wr_en   = en;
        id_is_load = ld;
    endtask

    task automatic set_rs(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2);
        id_rd_addr_1 = rs1;
        id_rd_use_1  = u1;
        id_rd_addr_2 = rs2;
        id_rd_use_2  = u2;
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        set_id(5'd5, 1'b1, 1'b0);
        set_rs(5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // Reset state with a live ID tag present
        chk("rst_ex_addr", wr_addr.EX, 0);
        chk("rst_mem_addr", wr_addr.MEM, 0);
        chk("rst_wb_addr", wr_addr.WB, 0);
        chk("rst_en_back", {wr_en.EX, wr_en.MEM, wr_en.WB}, 0);
        chk("rst_stall", stall, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("id_addr_pass", wr_addr.ID, 5);
        chk("id_en_pass", wr_en.ID, 1);

        set_rs(5'd17, 1'b0, 5'd22, 1'b0);
        #1;
        chk("rd1_id", rd_addr_1, {5'd17, 15'd0});
        chk("rd2_id", rd_addr_2, {5'd22, 15'd0});

        // Flow: rd=5 travels EX -> MEM -> WB
        rst = 1'b0;
        tick();
        chk("flow_ex_addr", wr_addr.EX, 5);
        chk("flow_ex_en", wr_en.EX, 1);
        set_id(5'd0, 1'b1, 1'b0);
        #1;
        chk("x0_id_en", wr_en.ID, 0);
        tick();
        chk("flow_mem_addr", wr_addr.MEM, 5);
        chk("flow_mem_en", wr_en.MEM, 1);
        chk("x0_ex_en", wr_en.EX, 0);
        set_id(5'd3, 1'b1, 1'b0);
        tick();
        chk("flow_wb_addr", wr_addr.WB, 5);
        chk("flow_wb_en", wr_en.WB, 1);
        chk("flow2_ex_addr", wr_addr.EX, 3);

        // Load-use: load rd=7 into EX, then a reader in ID
        set_id(5'd7, 1'b1, 1'b1);
        set_rs(5'd7, 1'b1, 5'd0, 1'b0);
        #1;
        chk("nonload_no_stall", stall, 0);
        tick();
        set_id(5'd2, 1'b1, 1'b0);
        set_rs(5'd7, 1'b0, 5'd0, 1'b0);
        #1;
        chk("lu_use0_no_stall", stall, 0);
        set_rs(5'd8, 1'b1, 5'd0, 1'b0);
        #1;
        chk("lu_rs8_no_stall", stall, 0);
        set_rs(5'd0, 1'b0, 5'd7, 1'b1);
        #1;
        chk("lu_rs2_stall", stall, 1);
        set_rs(5'd7, 1'b1, 5'd0, 1'b0);
        #1;
        chk("lu_rs1_stall", stall, 1);
        tick();
        chk("lu_bubble_en", wr_en.EX, 0);
        chk("lu_mem_addr", wr_addr.MEM, 7);
        chk("lu_mem_en", wr_en.MEM, 1);
        chk("lu_cnt1", stall_cnt, 1);
        chk("lu_single_cycle", stall, 0);

        // Load to x0 never causes a hazard
        set_id(5'd0, 1'b1, 1'b1);
        set_rs(5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        set_rs(5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        chk("x0_load_no_stall", stall, 0);

        // Flush squashes the ID tag
        set_id(5'd9, 1'b1, 1'b0);
        set_rs(5'd0, 1'b0, 5'd0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ex_en", wr_en.EX, 0);
        chk("flush_ex_addr", wr_addr.EX, 0);

        // Stall and flush together: one bubble, stall still reported
        set_id(5'd4, 1'b1, 1'b1);
        tick();
        set_id(5'd6, 1'b1, 1'b0);
        set_rs(5'd4, 1'b1, 5'd0, 1'b0);
        flush = 1'b1;
        #1;
        chk("sf_stall", stall, 1);
        tick();
        flush = 1'b0;
        chk("sf_ex_en", wr_en.EX, 0);
        chk("sf_ex_addr", wr_addr.EX, 0);
        chk("sf_mem_addr", wr_addr.MEM, 4);
        chk("sf_cnt2", stall_cnt, 2);

        // Saturation: 2^CntW+3 further load-use stalls on top of the two above
        for (int i = 0; i < (1 << CntW) + 3; i++) begin
            set_id(5'd10, 1'b1, 1'b1);
            set_rs(5'd0, 1'b0, 5'd0, 1'b0);
            tick();
            set_id(5'd0, 1'b0, 1'b0);
            set_rs(5'd10, 1'b1, 5'd0, 1'b0);
            tick();
            if (i == 3) chk("sat_mid_cnt", stall_cnt, 6);
        end
        chk("sat_cnt", stall_cnt, CntMax);

        // Async reset in the middle of a stall cycle
        set_id(5'd11, 1'b1, 1'b1);
        set_rs(5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        set_id(5'd13, 1'b1, 1'b0);
        set_rs(5'd11, 1'b1, 5'd0, 1'b0);
        #1;
        chk("ar_pre_stall", stall, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_cnt", stall_cnt, 0);
        chk("ar_ex_en", wr_en.EX, 0);
        chk("ar_mem", {wr_addr.MEM, wr_en.MEM}, 0);
        chk("ar_wb", {wr_addr.WB, wr_en.WB}, 0);
        chk("ar_stall", stall, 0);
        set_id(5'd12, 1'b1, 1'b0);
        set_rs(5'd0, 1'b0, 5'd0, 1'b0);
        #2;
        rst = 1'b0;
        tick();
        chk("post_rst_ex_addr", wr_addr.EX, 12);
        chk("post_rst_ex_en", wr_en.EX, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
